// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and the CU.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // Sequential PC step: one 32-bit instruction word.
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_ERR
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential PC+4 or word-aligned branch/jump target.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_sel_i,
    input  logic [XLEN-1:0] alu_target_i,
    output logic [XLEN-1:0] pc_next_o
);

    // Target low bits are dropped rather than trapped; PC+4 wraps modulo 2^32.
    always_comb begin
        if (pc_sel_i) begin
            pc_next_o = alu_target_i & ~XLEN'(3);
        end else begin
            pc_next_o = pc_i + PC_INC;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests words from a variable-latency
// instruction memory, holds the captured word for the CU until advance, and
// flags a memory that never answers.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        PCSel,
    input  logic [31:0] alu_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] I,
    output logic [31:0] PC,
    output logic        inst_valid,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         inst_valid_q, inst_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc_next;
    logic        timeout_hit;
    logic        resp_ok;

    pc_next_sel u_pc_next_sel (
        .pc_i         (pc_q),
        .pc_sel_i     (PCSel),
        .alu_target_i (alu_target),
        .pc_next_o    (pc_next)
    );

    // A response only counts while our request is actually on the bus.
    assign resp_ok     = imem_req_q & imem_valid;
    assign timeout_hit = imem_req_q & (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: PC, captured word, request, counter, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            fetch_err_q  <= fetch_err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and next-datapath logic; a response on the timeout edge wins.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        fetch_err_d  = fetch_err_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            S_FETCH: begin
                if (!imem_req_q) begin
                    // First cycle after reset: raise the registered request.
                    imem_req_d = 1'b1;
                    cnt_d      = '0;
                end else if (resp_ok) begin
                    instr_d      = imem_rdata;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_HOLD;
                end else if (timeout_hit) begin
                    fetch_err_d = 1'b1;
                    imem_req_d  = 1'b0;
                    state_d     = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    pc_d         = pc_next;
                    instr_d      = NOP_INSTR;
                    inst_valid_d = 1'b0;
                    imem_req_d   = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_FETCH;
                end
            end
            S_ERR: begin
                instr_d      = NOP_INSTR;
                inst_valid_d = 1'b0;
                imem_req_d   = 1'b0;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Outputs come straight from registers so they are glitch-free to the CU.
    always_comb begin
        imem_req   = imem_req_q;
        imem_addr  = pc_q;
        PC         = pc_q;
        I          = instr_q;
        inst_valid = inst_valid_q;
        fetch_err  = fetch_err_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected {PC, I} pairs,
// a monitor pops and compares each time a new instruction becomes valid.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        advance;
    logic        PCSel;
    logic [31:0] alu_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] I;
    logic [31:0] PC;
    logic        inst_valid;
    logic        fetch_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];
    logic        seen = 1'b0;
    logic [63:0] mon_e;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .TIMEOUT   (16),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .advance    (advance),
        .PCSel      (PCSel),
        .alu_target (alu_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .I          (I),
        .PC         (PC),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: one scoreboard pop per rising inst_valid.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (inst_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_inst: got PC %h I %h expected none", PC, I);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_pc", PC, mon_e[63:32]);
                chk("mon_I", I, mon_e[31:0]);
            end
        end else if (!inst_valid) begin
            seen = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, PC, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_I"}, I, NOP);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_err"}, 32'(fetch_err), 32'd0);
    endtask

    // Memory model: respond on the lat-th request cycle (1 = zero-wait).
    task automatic fetch(input int lat, input logic [31:0] data, input logic [31:0] exp_pc);
        bit ok = 1'b0;
        exp_q.push_back({exp_pc, data});
        for (int i = 0; i < 50; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_total++;
            $display("FAIL req_wait: got imem_req 0 expected 1 within 50 cycles");
            void'(exp_q.pop_back());
            return;
        end
        repeat (lat - 1) @(negedge clk);
        imem_rdata = data;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_advance(input logic sel, input logic [31:0] tgt);
        PCSel      = sel;
        alu_target = tgt;
        advance    = 1'b1;
        @(negedge clk);
        advance    = 1'b0;
        PCSel      = 1'b0;
        alu_target = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        advance    = 1'b0;
        PCSel      = 1'b0;
        alu_target = 32'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("req_before_edge", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("req_rise", 32'(imem_req), 32'd1);
        chk("addr0", imem_addr, 32'h0);

        // Zero-wait memory.
        fetch(1, 32'h0000_0003, 32'h0);
        chk("zw_valid", 32'(inst_valid), 32'd1);
        chk("zw_req_low", 32'(imem_req), 32'd0);

        // imem_valid in S_HOLD is ignored.
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        repeat (2) @(negedge clk);
        imem_valid = 1'b0;
        chk("hold_I", I, 32'h0000_0003);

        // Sequential advance.
        do_advance(1'b0, 32'h0);
        chk("adv_addr", imem_addr, 32'h4);
        chk("adv_I_nop", I, NOP);
        chk("adv_valid0", 32'(inst_valid), 32'd0);
        chk("adv_req", 32'(imem_req), 32'd1);

        // advance while not valid is ignored.
        PCSel      = 1'b1;
        alu_target = 32'h0000_0800;
        advance    = 1'b1;
        @(negedge clk);
        advance    = 1'b0;
        PCSel      = 1'b0;
        chk("ign_adv_pc", PC, 32'h4);

        fetch(5, 32'h0000_0023, 32'h4);

        do_advance(1'b1, 32'h0000_0010);
        fetch(2, 32'h0000_0033, 32'h10);
        do_advance(1'b1, 32'h0000_0103);
        chk("tgt_align", PC, 32'h0000_0100);
        fetch(1, 32'h0000_006F, 32'h100);
        do_advance(1'b1, 32'hFFFF_FFFE);
        chk("tgt_top", PC, 32'hFFFF_FFFC);
        fetch(3, 32'h0000_0067, 32'hFFFF_FFFC);
        do_advance(1'b0, 32'h0);
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        fetch(1, 32'h0000_0093, 32'h0);

        // Silent memory: request rose at the advance edge.
        do_advance(1'b0, 32'h0);
        repeat (15) @(negedge clk);
        chk("to_err_before", 32'(fetch_err), 32'd0);
        chk("to_req_before", 32'(imem_req), 32'd1);
        @(negedge clk);
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req_low", 32'(imem_req), 32'd0);
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_0ACE;
        advance    = 1'b1;
        repeat (3) @(negedge clk);
        imem_valid = 1'b0;
        advance    = 1'b0;
        chk("err_sticky", 32'(fetch_err), 32'd1);
        chk("err_valid0", 32'(inst_valid), 32'd0);
        chk("err_I", I, NOP);
        chk("err_pc", PC, 32'h4);

        // Timeout boundary: answer on the 16th request cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch(16, 32'h0000_00AB, 32'h0);
        chk("bnd_err", 32'(fetch_err), 32'd0);
        chk("bnd_valid", 32'(inst_valid), 32'd1);

        // Async reset during a fetch wait.
        do_advance(1'b0, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_fetch");
        @(negedge clk);
        rst = 1'b0;
        fetch(1, 32'h0000_0003, 32'h0);
        do_advance(1'b1, 32'h0000_0040);
        fetch(2, 32'h0000_0017, 32'h40);

        // Async reset while holding an instruction.
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
